// File: rtl/ring_tuner_ctrl.sv
// Multi-channel closed-loop ring heater controller:
// per-channel sweep to the power minimum, then dither-track drift.
module ring_tuner_ctrl #(
  parameter int NUM_CH     = 4,
  parameter int CODE_W     = 8,
  parameter int PWR_W      = 10,
  parameter int SETTLE_CYC = 16,
  parameter int LOSS_THR   = 64,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        enable,
  input  logic                     pwr_valid,
  input  logic [CH_W-1:0]          pwr_ch,
  input  logic [PWR_W-1:0]         pwr_data,
  output logic [NUM_CH*CODE_W-1:0] heater_code,
  output logic [NUM_CH-1:0]        locked,
  output logic [NUM_CH-1:0]        lock_lost
);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    TRACK
  } state_t;

  localparam logic [CODE_W-1:0] CODE_MAX = '1;
  localparam logic [7:0]        SETTLE   = 8'(SETTLE_CYC);
  localparam logic [PWR_W:0]    THR      = (PWR_W+1)'(LOSS_THR);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t            st_q, st_n;
    logic [CODE_W-1:0] code_q, code_n;
    logic [CODE_W-1:0] bestc_q, bestc_n;
    logic [PWR_W-1:0]  best_q, best_n;
    logic [PWR_W-1:0]  ref_q, ref_n;
    logic [7:0]        cnt_q, cnt_n;
    logic              dir_q, dir_n, dir_t;
    logic              refv_q, refv_n;
    logic              lost_q, lost_n;
    logic              load, take;
    logic [PWR_W:0]    lim;

    assign lim  = {1'b0, best_q} + THR;
    assign take = pwr_valid
               && (pwr_ch == CH_W'(g))
               && (cnt_q == 8'd0)
               && (st_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q    <= IDLE;
        code_q  <= '0;
        bestc_q <= '0;
        best_q  <= '1;
        ref_q   <= '0;
        cnt_q   <= '0;
        dir_q   <= 1'b1;
        refv_q  <= 1'b0;
        lost_q  <= 1'b0;
      end else begin
        st_q    <= st_n;
        code_q  <= code_n;
        bestc_q <= bestc_n;
        best_q  <= best_n;
        ref_q   <= ref_n;
        cnt_q   <= cnt_n;
        dir_q   <= dir_n;
        refv_q  <= refv_n;
        lost_q  <= lost_n;
      end
    end

    always_comb begin
      st_n    = st_q;
      code_n  = code_q;
      bestc_n = bestc_q;
      best_n  = best_q;
      ref_n   = ref_q;
      dir_n   = dir_q;
      dir_t   = dir_q;
      refv_n  = refv_q;
      lost_n  = 1'b0;
      load    = 1'b0;
      cnt_n   = cnt_q;
      if (!enable[g]) begin
        st_n   = IDLE;
        code_n = '0;
      end else begin
        unique case (st_q)
          IDLE: begin
            st_n    = SWEEP;
            code_n  = '0;
            best_n  = '1;
            bestc_n = '0;
            dir_n   = 1'b1;
            load    = 1'b1;
          end
          SWEEP: if (take) begin
            if (pwr_data < best_q) begin
              best_n  = pwr_data;
              bestc_n = code_q;
            end
            if (code_q != CODE_MAX) begin
              code_n = code_q + 1'b1;
            end else begin
              code_n = bestc_n;
              st_n   = TRACK;
              dir_n  = 1'b1;
              refv_n = 1'b0;
            end
          end
          TRACK: if (take) begin
            ref_n  = pwr_data;
            refv_n = 1'b1;
            if (refv_q && ({1'b0, pwr_data} > lim)) begin
              lost_n  = 1'b1;
              st_n    = SWEEP;
              code_n  = '0;
              best_n  = '1;
              bestc_n = '0;
              load    = 1'b1;
            end else if (refv_q) begin
              // power rose since last step: reverse the dither
              dir_t = (pwr_data > ref_q) ? ~dir_q : dir_q;
              dir_n = dir_t;
              if (dir_t && code_q == CODE_MAX)
                dir_n = ~dir_t;
              else if (!dir_t && code_q == '0)
                dir_n = ~dir_t;
              else if (dir_t)
                code_n = code_q + 1'b1;
              else
                code_n = code_q - 1'b1;
            end
          end
          default: st_n = IDLE;
        endcase
      end
      if (load || code_n != code_q)
        cnt_n = SETTLE;
      else if (cnt_q != 8'd0)
        cnt_n = cnt_q - 8'd1;
    end

    assign heater_code[g*CODE_W +: CODE_W] = code_q;
    assign locked[g]    = (st_q == TRACK);
    assign lock_lost[g] = lost_q;
  end

endmodule

// File: tb/tb_ring_tuner_ctrl.sv
// Bench for ring_tuner_ctrl: random-paced samples against
// a per-channel behavioural model of sweep, lock and dither.
module tb_ring_tuner_ctrl;
  localparam int NCH = 4;
  localparam int CW  = 4;
  localparam int PW  = 10;
  localparam int ST  = 2;
  localparam int THR = 64;
  localparam int MI = 0, MS = 1, MT = 2;

  logic            clk;
  logic            rst_n;
  logic [NCH-1:0]  enable;
  logic            pwr_valid;
  logic [1:0]      pwr_ch;
  logic [PW-1:0]   pwr_data;
  logic [NCH*CW-1:0] heater_code;
  logic [NCH-1:0]  locked;
  logic [NCH-1:0]  lock_lost;

  ring_tuner_ctrl #(
    .NUM_CH(NCH), .CODE_W(CW), .PWR_W(PW),
    .SETTLE_CYC(ST), .LOSS_THR(THR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .pwr_valid(pwr_valid), .pwr_ch(pwr_ch),
    .pwr_data(pwr_data), .heater_code(heater_code),
    .locked(locked), .lock_lost(lock_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [NCH-1:0] en_r;
  int m_st[NCH], m_code[NCH], m_best[NCH], m_bestc[NCH];
  int m_dir[NCH], m_ref[NCH], m_refv[NCH], m_lost[NCH];
  int m_chg[NCH];
  int lo[NCH], hi[NCH];

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic expire(string tag);
    total++;
    bad++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  function automatic int pwr(int c);
    int d;
    d = 0;
    if (m_code[c] < lo[c]) d = lo[c] - m_code[c];
    if (m_code[c] > hi[c]) d = m_code[c] - hi[c];
    return 100 + 20 * d;
  endfunction

  function automatic bit ready(int c);
    return m_st[c] != MI && (cyc - m_chg[c]) >= ST;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_st[i] = MI; m_code[i] = 0; m_best[i] = 1023;
      m_bestc[i] = 0; m_dir[i] = 1; m_ref[i] = 0;
      m_refv[i] = 0; m_lost[i] = 0; m_chg[i] = -100;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NCH; i++) begin
      bit take;
      int oc, d, dt;
      oc = m_code[i];
      d = int'(pwr_data);
      m_lost[i] = 0;
      take = pwr_valid && int'(pwr_ch) == i && ready(i);
      if (!en_r[i]) begin
        m_st[i] = MI; m_code[i] = 0;
      end else if (m_st[i] == MI) begin
        m_st[i] = MS; m_code[i] = 0; m_best[i] = 1023;
        m_bestc[i] = 0; m_dir[i] = 1; m_chg[i] = cyc + 1;
      end else if (take && m_st[i] == MS) begin
        if (d < m_best[i]) begin
          m_best[i] = d; m_bestc[i] = m_code[i];
        end
        if (m_code[i] < 15) m_code[i]++;
        else begin
          m_code[i] = m_bestc[i]; m_st[i] = MT;
          m_dir[i] = 1; m_refv[i] = 0;
        end
      end else if (take && m_st[i] == MT) begin
        if (m_refv[i] && d > m_best[i] + THR) begin
          m_lost[i] = 1; m_st[i] = MS; m_code[i] = 0;
          m_best[i] = 1023; m_bestc[i] = 0;
          m_chg[i] = cyc + 1;
        end else if (m_refv[i]) begin
          dt = (d > m_ref[i]) ? 1 - m_dir[i] : m_dir[i];
          if (dt == 1 && m_code[i] == 15) m_dir[i] = 0;
          else if (dt == 0 && m_code[i] == 0) m_dir[i] = 1;
          else begin
            m_dir[i] = dt;
            m_code[i] += (dt == 1) ? 1 : -1;
          end
        end
        m_ref[i] = d; m_refv[i] = 1;
      end
      if (m_code[i] != oc) m_chg[i] = cyc + 1;
    end
    cyc++;
  endtask

  task automatic check_all();
    logic [NCH*CW-1:0] ec;
    logic [NCH-1:0] el, ell;
    for (int i = 0; i < NCH; i++) begin
      ec[i*CW +: CW] = CW'(m_code[i]);
      el[i] = (m_st[i] == MT);
      ell[i] = (m_lost[i] != 0);
    end
    chk("heater_code", 32'(heater_code), 32'(ec));
    chk("locked", 32'(locked), 32'(el));
    chk("lock_lost", 32'(lock_lost), 32'(ell));
  endtask

  task automatic run_cycle(logic [NCH-1:0] en, bit v,
                           int ch, int d);
    en_r = en;
    enable = en;
    pwr_valid = v;
    pwr_ch = 2'(ch);
    pwr_data = PW'(d);
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic junk_cycle();
    int j;
    j = $urandom_range(0, NCH - 1);
    if (ready(j)) run_cycle(en_r, 0, 0, 0);
    else run_cycle(en_r, 1, j, $urandom_range(0, 1023));
  endtask

  task automatic wait_ready(int c);
    for (int k = 0; k < 20 && !ready(c); k++) junk_cycle();
    if (!ready(c)) expire("ready_wait");
  endtask

  task automatic sample(int c);
    wait_ready(c);
    run_cycle(en_r, 1, c, pwr(c));
  endtask

  function automatic int code_of(int c);
    return int'(heater_code[c*CW +: CW]);
  endfunction

  initial begin
    bit done;
    int c;
    rst_n = 1'b0; en_r = '0; enable = '0;
    pwr_valid = 1'b0; pwr_ch = '0; pwr_data = '0;
    for (int i = 0; i < NCH; i++) begin
      lo[i] = 9; hi[i] = 9;
    end
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) run_cycle(4'b0000, 0, 0, 0);

    run_cycle(4'b0001, 0, 0, 0);
    repeat (16) sample(0);
    chk("sweep_code", 32'(code_of(0)), 32'd9);
    chk("sweep_lock", 32'(locked[0]), 32'd1);

    lo[0] = 11; hi[0] = 11;
    repeat (12) sample(0);
    chk("dither_rng",
        32'(code_of(0) >= 10 && code_of(0) <= 12), 32'd1);
    chk("dither_lock", 32'(locked[0]), 32'd1);

    wait_ready(0);
    run_cycle(en_r, 1, 0, 164);
    chk("thr_164_lock", 32'(locked[0]), 32'd1);
    wait_ready(0);
    run_cycle(en_r, 1, 0, 165);
    chk("thr_165_pulse", 32'(lock_lost[0]), 32'd1);
    chk("thr_165_code", 32'(code_of(0)), 32'd0);
    chk("thr_165_lock", 32'(locked[0]), 32'd0);
    run_cycle(en_r, 0, 0, 0);
    chk("pulse_width", 32'(lock_lost[0]), 32'd0);

    run_cycle(4'b0000, 0, 0, 0);
    lo[0] = 15; hi[0] = 15;
    run_cycle(4'b0001, 0, 0, 0);
    repeat (16) sample(0);
    chk("sat_lock", 32'(code_of(0)), 32'd15);
    sample(0);
    sample(0);
    chk("sat_hold", 32'(code_of(0)), 32'd15);
    sample(0);
    chk("sat_flip", 32'(code_of(0)), 32'd14);

    run_cycle(4'b0000, 0, 0, 0);
    lo[0] = 9; hi[0] = 9;
    lo[1] = 4; hi[1] = 4;
    lo[2] = 3; hi[2] = 3;
    lo[3] = 5; hi[3] = 6;
    en_r = 4'b1011;
    done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      logic [NCH-1:0] e;
      e = en_r;
      if (n == 30) e[1] = 1'b0;
      if (n == 40) e[2] = 1'b1;
      c = $urandom_range(0, NCH - 1);
      if (ready(c) && m_st[c] == MS)
        run_cycle(e, 1, c, pwr(c));
      else if (ready(c))
        run_cycle(e, 0, 0, 0);
      else
        run_cycle(e, 1, c, $urandom_range(0, 1023));
      done = m_st[0] == MT && m_st[2] == MT && m_st[3] == MT;
    end
    if (!done) expire("multi_lock");
    chk("multi_c0", 32'(code_of(0)), 32'd9);
    chk("multi_c1", 32'(code_of(1)), 32'd0);
    chk("multi_c2", 32'(code_of(2)), 32'd3);
    chk("multi_tie", 32'(code_of(3)), 32'd5);
    chk("multi_lock", 32'(locked), 32'b1101);

    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_code", 32'(heater_code), 32'd0);
    chk("arst_lock", 32'(locked), 32'd0);
    chk("arst_lost", 32'(lock_lost), 32'd0);
    model_reset();
    en_r = '0;
    enable = '0;
    pwr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) run_cycle(4'b0000, 1, 0, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
